// File: rtl/dm_copy_engine.sv
// ---------------------------------------------------------------------------
// dm_copy_engine
//
// Word-granular memory copy engine that masters the data-memory (DM) port.
// A copy request (src, dst, len) is range-checked, then each word is moved
// with one READ cycle followed by one WRITE cycle (2 cycles per word).
// Overlapping copies where the destination lies above the source are run
// last-word-first so the source is never clobbered before it is read
// (memmove semantics).
//
// Optional feature (macro DM_COPY_FILL_EN):
//   Adds fill_mode / fill_data inputs. With fill_mode = 1 the engine skips
//   the READ phase and writes fill_data to every destination word (1 cycle
//   per word). Without the macro only copy behaviour exists.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle copy request, sampled only when idle
//   src_addr   in   byte address of first source word (word aligned)
//   dst_addr   in   byte address of first destination word (word aligned)
//   len        in   number of words to copy (0 is legal)
//   abort      in   finish the current word, then stop
//   fill_mode  in   (DM_COPY_FILL_EN only) fill instead of copy
//   fill_data  in   (DM_COPY_FILL_EN only) word written in fill mode
//   MemWrite   out  DM write enable
//   MemAddr    out  DM byte address
//   MemData    out  DM write data
//   pc         out  constant PC_TAG, identifies the engine in DM traces
//   ReadData   in   DM combinational read data for MemAddr
//   busy       out  copy in progress (CHECK, READ, WRITE)
//   done       out  one-cycle pulse on completion, abort or error
//   err        out  sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module dm_copy_engine #(
  parameter int unsigned DM_WORDS = 3072,
  parameter logic [31:0] PC_TAG   = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [11:0] len,
  input  logic        abort,
`ifdef DM_COPY_FILL_EN
  input  logic        fill_mode,
  input  logic [31:0] fill_data,
`endif
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic [31:0] pc,
  input  logic [31:0] ReadData,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;        // current source byte address
  logic [31:0] dst_q, dst_d;        // current destination byte address
  logic [11:0] cnt_q, cnt_d;        // words still to move
  logic [31:0] buf_q, buf_d;        // word captured in READ, stored in WRITE
  logic        desc_q, desc_d;      // 1: walk addresses downwards
  logic        abort_pend_q, abort_pend_d;
  logic        err_q, err_d;

  logic        fill_now;            // fill transfer in progress
  logic [31:0] fill_word;

`ifdef DM_COPY_FILL_EN
  logic        fill_q, fill_d;
  logic [31:0] fdata_q, fdata_d;

  assign fill_now  = fill_q;
  assign fill_word = fdata_q;
`else
  assign fill_now  = 1'b0;
  assign fill_word = 32'd0;
`endif

  // Range check: word index + len must not exceed DM_WORDS. The sums are
  // carried one bit wider than the operands so they can never wrap.
  logic [32:0] src_end, dst_end;
  logic [33:0] src_lim;
  logic [31:0] last_off;
  logic        misaligned, out_of_range, overlap;

  assign src_end  = {3'b000, src_q[31:2]} + {21'd0, cnt_q};
  assign dst_end  = {3'b000, dst_q[31:2]} + {21'd0, cnt_q};
  assign src_lim  = {2'b00, src_q} + {20'd0, cnt_q, 2'b00};
  // Byte offset of the last word, used to start a descending walk.
  assign last_off = {18'd0, cnt_q - 12'd1, 2'b00};

  assign misaligned   = (dst_q[1:0] != 2'b00) ||
                        (!fill_now && (src_q[1:0] != 2'b00));
  assign out_of_range = (cnt_q != 12'd0) &&
                        ((dst_end > 33'(DM_WORDS)) ||
                         (!fill_now && (src_end > 33'(DM_WORDS))));
  // Destination starts inside the source block above its base: copying
  // upwards would overwrite source words before they are read.
  assign overlap      = !fill_now && (dst_q > src_q) &&
                        ({2'b00, dst_q} < src_lim);

  assign pc  = PC_TAG;
  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      src_q        <= 32'd0;
      dst_q        <= 32'd0;
      cnt_q        <= 12'd0;
      buf_q        <= 32'd0;
      desc_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      desc_q       <= desc_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
    end
  end

`ifdef DM_COPY_FILL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q  <= 1'b0;
      fdata_q <= 32'd0;
    end else begin
      fill_q  <= fill_d;
      fdata_q <= fdata_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    desc_d       = desc_q;
    abort_pend_d = abort_pend_q;
    err_d        = err_q;
`ifdef DM_COPY_FILL_EN
    fill_d       = fill_q;
    fdata_d      = fdata_q;
`endif
    MemWrite     = 1'b0;
    MemAddr      = 32'd0;
    MemData      = 32'd0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          cnt_d        = len;
          desc_d       = 1'b0;
          abort_pend_d = 1'b0;
          err_d        = 1'b0;
`ifdef DM_COPY_FILL_EN
          fill_d       = fill_mode;
          fdata_d      = fill_data;
`endif
          state_d      = S_CHECK;
        end
      end

      S_CHECK: begin
        busy = 1'b1;
        if (misaligned || out_of_range) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == 12'd0) begin
          state_d = S_DONE;
        end else begin
          desc_d = overlap;
          if (overlap) begin
            src_d = src_q + last_off;
            dst_d = dst_q + last_off;
          end
          state_d = fill_now ? S_WRITE : S_READ;
        end
      end

      S_READ: begin
        busy    = 1'b1;
        MemAddr = src_q;
        buf_d   = ReadData;
        // Remember the abort so the word being read is still written.
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        state_d = S_WRITE;
      end

      S_WRITE: begin
        busy     = 1'b1;
        MemWrite = 1'b1;
        MemAddr  = dst_q;
        MemData  = fill_now ? fill_word : buf_q;
        src_d    = desc_q ? (src_q - 32'd4) : (src_q + 32'd4);
        dst_d    = desc_q ? (dst_q - 32'd4) : (dst_q + 32'd4);
        cnt_d    = cnt_q - 12'd1;
        if ((cnt_q == 12'd1) || abort || abort_pend_q) begin
          state_d = S_DONE;
        end else begin
          state_d = fill_now ? S_WRITE : S_READ;
        end
      end

      S_DONE: begin
        done         = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
`timescale 1ns/1ps
module tb_dm_copy_engine;
  localparam int DMW = 3072;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [11:0] len;
  logic        MemWrite;
  logic [31:0] MemAddr, MemData, pc, ReadData;
  logic        busy, done, err;
`ifdef DM_COPY_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_data;
`endif

  logic [31:0] dm     [0:DMW-1];
  logic [31:0] snap   [0:DMW-1];
  logic [31:0] exp_dm [0:DMW-1];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        busy;
    logic        mw;
    logic [31:0] addr;
    logic        chk_data;
    logic [31:0] data;
    logic        done;
    logic        err;
  } ent_t;

  ent_t        trace[$];
  ent_t        cur;
  int          cyc;
  int          done_at;
  int          wr_cnt;
  logic [31:0] wlog[$];

  always #5 clk = ~clk;

  dm_copy_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .abort    (abort),
`ifdef DM_COPY_FILL_EN
    .fill_mode(fill_mode),
    .fill_data(fill_data),
`endif
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
    .pc       (pc),
    .ReadData (ReadData),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Data memory: combinational read, write on the rising edge.
  assign ReadData = (MemAddr[31:2] < 30'(DMW)) ? dm[MemAddr[13:2]] : 32'd0;
  always @(posedge clk) begin
    if (MemWrite && (MemAddr[31:2] < 30'(DMW))) dm[MemAddr[13:2]] <= MemData;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic b, input logic mw, input logic [31:0] a,
                              input logic cd, input logic [31:0] dt,
                              input logic dn, input logic er);
    ent_t e;
    e.busy = b; e.mw = mw; e.addr = a; e.chk_data = cd;
    e.data = dt; e.done = dn; e.err = er;
    return e;
  endfunction

  // Compare process: one expected entry per cycle while a transfer runs.
  always @(negedge clk) begin
    cyc++;
    if (done) done_at = cyc;
    if (MemWrite) begin
      wr_cnt++;
      wlog.push_back(MemAddr);
    end
    if (trace.size() > 0) begin
      cur = trace.pop_front();
      chk("busy", {31'd0, busy}, {31'd0, cur.busy});
      chk("MemWrite", {31'd0, MemWrite}, {31'd0, cur.mw});
      chk("MemAddr", MemAddr, cur.addr);
      if (cur.chk_data) chk("MemData", MemData, cur.data);
      chk("done", {31'd0, done}, {31'd0, cur.done});
      chk("err", {31'd0, err}, {31'd0, cur.err});
    end
  end

  // Reference model: memmove semantics, 2 cycles/word (1 in fill mode),
  // abort finishes the word in flight.
  task automatic build_trace(input logic [31:0] s, input logic [31:0] d, input int n,
                             input int ab, input bit fm, input logic [31:0] fd);
    bit bad, desc;
    int nw, w, j;
    logic [31:0] v;
    for (int i = 0; i < DMW; i++) begin
      snap[i]   = dm[i];
      exp_dm[i] = dm[i];
    end
    bad = (d[1:0] != 2'b00) || (!fm && (s[1:0] != 2'b00));
    if (n > 0) begin
      if (longint'(d >> 2) + n > DMW) bad = 1;
      if (!fm && (longint'(s >> 2) + n > DMW)) bad = 1;
    end
    trace.push_back(mk(1, 0, 32'd0, 1, 32'd0, 0, 0));
    if (!bad && n > 0) begin
      desc = !fm && (d > s) && (longint'(d) < longint'(s) + 4 * n);
      nw = n;
      if (ab >= 2) begin
        j = fm ? (ab - 2) : ((ab - 2) / 2);
        if (j + 1 < nw) nw = j + 1;
      end
      for (int i = 0; i < nw; i++) begin
        w = desc ? (n - 1 - i) : i;
        if (!fm) trace.push_back(mk(1, 0, s + 32'(4 * w), 0, 32'd0, 0, 0));
        v = fm ? fd : snap[int'(s >> 2) + w];
        exp_dm[int'(d >> 2) + w] = v;
        trace.push_back(mk(1, 1, d + 32'(4 * w), 1, v, 0, 0));
      end
    end
    trace.push_back(mk(0, 0, 32'd0, 1, 32'd0, 1, bad));
    trace.push_back(mk(0, 0, 32'd0, 1, 32'd0, 0, bad));
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                     input int ab, input bit fm, input logic [31:0] fd);
    int k, mism;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n[11:0];
    start    = 1'b1;
`ifdef DM_COPY_FILL_EN
    fill_mode = fm;
    fill_data = fd;
`endif
    @(posedge clk);
    cyc = 0; done_at = -1; wr_cnt = 0; wlog.delete();
    build_trace(s, d, n, ab, fm, fd);
    #2 start = 1'b0;
    k = 1;
    while (trace.size() > 0 && k < 300) begin
      abort = (k == ab);
      @(posedge clk);
      #2;
      k++;
    end
    abort = 1'b0;
    if (trace.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL timeout: %0d trace entries left, expected 0", trace.size());
      trace.delete();
    end
    mism = 0;
    for (int i = 0; i < DMW; i++) if (dm[i] !== exp_dm[i]) mism++;
    chk("dm_final", 32'(mism), 32'd0);
  endtask

  logic [31:0] s_r, d_r, keep;
  int n_r, ab_r;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; len = 12'd0;
`ifdef DM_COPY_FILL_EN
    fill_mode = 1'b0; fill_data = 32'd0;
`endif
    for (int i = 0; i < DMW; i++) dm[i] = $urandom;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_MemAddr", MemAddr, 32'd0);
    chk("rst_MemData", MemData, 32'd0);
    chk("pc", pc, 32'h0000_3000);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic copy of 1,2,3,4
    for (int i = 0; i < 4; i++) dm[i] = 32'(i + 1);
    run(32'h0, 32'h100, 4, 0, 0, 32'd0);
    chk("t1_done_at", 32'(done_at), 32'd10);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_dm", dm[64 + i], 32'(i + 1));
    chk("t1_err", {31'd0, err}, 32'd0);

    // Overlapping copy runs downwards
    dm[0] = 32'hA; dm[1] = 32'hB; dm[2] = 32'hC; dm[3] = 32'hD;
    run(32'h0, 32'h4, 4, 0, 0, 32'd0);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd4);
    if (wlog.size() == 4) begin
      chk("t2_order0", wlog[0], 32'h10);
      chk("t2_order1", wlog[1], 32'hC);
      chk("t2_order2", wlog[2], 32'h8);
      chk("t2_order3", wlog[3], 32'h4);
    end
    chk("t2_dm1", dm[1], 32'hA);
    chk("t2_dm2", dm[2], 32'hB);
    chk("t2_dm3", dm[3], 32'hC);
    chk("t2_dm4", dm[4], 32'hD);

    // Out-of-range source, then zero length
    run(32'h2FFC, 32'h100, 2, 0, 0, 32'd0);
    chk("t3_done_at", 32'(done_at), 32'd2);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd0);
    run(32'h10, 32'h20, 0, 0, 0, 32'd0);
    chk("t3_len0_done_at", 32'(done_at), 32'd2);
    chk("t3_len0_err", {31'd0, err}, 32'd0);

    // Abort during the 2nd READ of an 8-word copy
    run(32'h0, 32'h300, 8, 4, 0, 32'd0);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t4_done_at", 32'(done_at), 32'd6);

    // Reset during the 3rd WRITE
    for (int i = 0; i < 8; i++) dm[i] = 32'h5500 + 32'(i);
    dm[130] = 32'hDEAD_BEEF;
    keep    = dm[130];
    @(negedge clk);
    src_addr = 32'h0; dst_addr = 32'h200; len = 12'd8; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("t5_mw_before", {31'd0, MemWrite}, 32'd1);
    chk("t5_addr_before", MemAddr, 32'h208);
    reset = 1'b0;
    #1;
    chk("t5_mw_rst", {31'd0, MemWrite}, 32'd0);
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    chk("t5_addr_rst", MemAddr, 32'd0);
    chk("t5_done_rst", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_dm_kept", dm[130], keep);
    chk("t5_dm_prev", dm[129], 32'h5501);
    chk("t5_busy_after", {31'd0, busy}, 32'd0);

`ifdef DM_COPY_FILL_EN
    run(32'h0, 32'h78, 3, 0, 1, 32'hf00f_0ff0);
    chk("t6_done_at", 32'(done_at), 32'd5);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd3);
    if (wlog.size() == 3) begin
      chk("t6_a0", wlog[0], 32'h78);
      chk("t6_a1", wlog[1], 32'h7C);
      chk("t6_a2", wlog[2], 32'h80);
    end
    chk("t6_dm", dm[32], 32'hf00f_0ff0);
`endif

    // Randomized copies
    for (int t = 0; t < 40; t++) begin
      s_r  = 32'($urandom_range(0, 63)) * 32'd4;
      d_r  = 32'($urandom_range(0, 63)) * 32'd4;
      n_r  = $urandom_range(0, 20);
      ab_r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n_r + 2) : 0;
      if ($urandom_range(0, 9) == 0) s_r = s_r | 32'h2;
      if ($urandom_range(0, 9) == 0) d_r = 32'(DMW - $urandom_range(1, 12)) * 32'd4;
`ifdef DM_COPY_FILL_EN
      run(s_r, d_r, n_r, ab_r, ($urandom_range(0, 3) == 0), $urandom);
`else
      run(s_r, d_r, n_r, ab_r, 1'b0, 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
